// File: rtl/kgp_if_pkg.sv
// Shared definitions for the instruction fetch unit: datapath widths, the
// halt opcode and the fetch FSM state encoding.
package kgp_if_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;

  // Word that stops fetching when IF_HALT_DETECT_EN is defined.
  localparam logic [INSTR_W-1:0] HALT_OPCODE = 32'hFFFF_FFFF;

  // RUN    : normal streaming, one request issued per cycle
  // HOLD   : consumer stalled, skid buffer may hold the in-flight response
  // REFILL : first cycle after reset or redirect, nothing in flight
  typedef enum logic [1:0] {
    REFILL = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2
  } if_state_e;

  // Word address increment; wraps 8'hFF -> 8'h00 through natural truncation.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer that parks an instruction memory response that
// arrives while the consumer is stalled. Flush and reset empty it; load has
// priority over pop.
module if_skid_buf
  import kgp_if_pkg::*;
(
  input  logic               clock,
  input  logic               rst,
  input  logic               load_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] data_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] data_o,
  output logic [PC_W-1:0]    pc_o
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_data;
  logic [PC_W-1:0]    r_pc;

  // Entry storage: reset/flush empty it, load captures, pop releases.
  always_ff @(posedge clock) begin
    if (rst || flush_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pc    <= '0;
    end else if (load_i) begin
      r_valid <= 1'b1;
      r_data  <= data_i;
      r_pc    <= pc_i;
    end else if (pop_i) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign pc_o    = r_pc;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage. Issues one word address per unstalled cycle from
// a registered PC; the memory answers one cycle later and the answer is
// registered onto instr_o/npc_o/valid_o (PC-to-valid latency of 2 cycles).
//
// Handshake: valid_o says instr_o/npc_o carry a real instruction; stall_i is
// the consumer's "not ready". An instruction is transferred on a cycle where
// valid_o=1 and stall_i=0; while stall_i=1 the outputs are held unchanged.
// Redirect squashes everything in flight and takes priority over stall.
//
// Optional feature macro: IF_HALT_DETECT_EN adds halt_o and stops fetching
// after the halt opcode has been handed to the consumer.
module if_fetch_unit
  import kgp_if_pkg::*;
(
  input  logic               clock,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    npc_o,
  output logic               valid_o,
  output if_state_e          state_o
`ifdef IF_HALT_DETECT_EN
  ,
  output logic               halt_o
`endif
);

  // Fetch state
  logic [PC_W-1:0]    r_pc;
  logic               r_inflight_v;
  logic [PC_W-1:0]    r_inflight_pc;
  if_state_e          r_state;

  // Registered outputs
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_npc;
  logic               r_valid;

  // Skid buffer interface
  logic               w_skid_valid;
  logic [INSTR_W-1:0] w_skid_data;
  logic [PC_W-1:0]    w_skid_pc;
  logic               w_skid_load;
  logic               w_skid_pop;
  logic               w_skid_flush;

  // High while fetching must be blocked by a halt (always low without the feature)
  logic               w_halt_block;

`ifdef IF_HALT_DETECT_EN
  logic               r_halt;
  logic               w_halt_hit;

  // The halt word counts once the consumer takes it (presented and not stalled).
  assign w_halt_hit   = r_valid & ~stall_i & (r_instr == HALT_OPCODE);
  assign w_halt_block = r_halt | w_halt_hit;

  // Sticky halt flag; only reset clears it, redirects do not.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_halt <= 1'b0;
    end else if (w_halt_hit) begin
      r_halt <= 1'b1;
    end
  end

  assign halt_o = r_halt;
`else
  assign w_halt_block = 1'b0;
`endif

  // A response can only be in flight during a stall if it was issued in the
  // last unstalled cycle, and no request is issued while stalled, so the skid
  // entry and an in-flight request never coexist.
  assign w_skid_flush = redirect_i | w_halt_block;
  assign w_skid_load  = stall_i & r_inflight_v & ~w_skid_flush;
  assign w_skid_pop   = ~stall_i & w_skid_valid & ~w_skid_flush;

  if_skid_buf u_skid (
    .clock   (clock),
    .rst     (rst),
    .load_i  (w_skid_load),
    .pop_i   (w_skid_pop),
    .flush_i (w_skid_flush),
    .data_i  (imem_rdata_i),
    .pc_i    (r_inflight_pc),
    .valid_o (w_skid_valid),
    .data_o  (w_skid_data),
    .pc_o    (w_skid_pc)
  );

  // Fetch FSM with PC, in-flight tracking and registered outputs.
  // Priority: reset > halt > redirect > stall > normal streaming.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_pc          <= '0;
      r_inflight_v  <= 1'b0;
      r_inflight_pc <= '0;
      r_instr       <= '0;
      r_npc         <= '0;
      r_valid       <= 1'b0;
      r_state       <= REFILL;
    end else if (w_halt_block) begin
      // Frozen: PC holds, nothing issued, outputs show a bubble.
      r_inflight_v  <= 1'b0;
      r_instr       <= '0;
      r_valid       <= 1'b0;
      r_state       <= HOLD;
    end else if (redirect_i) begin
      // Squash in-flight work; the old response arriving next cycle is ignored.
      r_pc          <= redirect_pc_i;
      r_inflight_v  <= 1'b0;
      r_instr       <= '0;
      r_npc         <= '0;
      r_valid       <= 1'b0;
      r_state       <= REFILL;
    end else if (stall_i) begin
      // Outputs and PC hold; any arriving response moves into the skid buffer.
      r_inflight_v  <= 1'b0;
      r_state       <= HOLD;
    end else begin
      // Issue the next request and advance the output register.
      r_pc          <= pc_inc(r_pc);
      r_inflight_v  <= 1'b1;
      r_inflight_pc <= r_pc;
      r_state       <= RUN;
      if (w_skid_valid) begin
        // Older data parked during the stall goes out first.
        r_instr <= w_skid_data;
        r_npc   <= pc_inc(w_skid_pc);
        r_valid <= 1'b1;
      end else if (r_inflight_v) begin
        r_instr <= imem_rdata_i;
        r_npc   <= pc_inc(r_inflight_pc);
        r_valid <= 1'b1;
      end else begin
        r_instr <= '0;
        r_valid <= 1'b0;
      end
    end
  end

  assign imem_addr_o = r_pc;
  assign instr_o     = r_instr;
  assign npc_o       = r_npc;
  assign valid_o     = r_valid;
  assign state_o     = r_state;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit. The reference model treats the fetch unit as an
// address stream: after reset it delivers addresses 0,1,2,... and after a
// redirect it restarts at the target; every unstalled, non-redirect cycle
// adds one address to the stream, and each delivered entry is
// {mem[addr], addr+1}. A negedge monitor pops the expected queue on every
// transfer (valid_o=1, stall_i=0, no redirect) and checks holds and bubbles.
module tb_if_fetch_unit;
  import kgp_if_pkg::*;

  // Clock / reset / DUT signals
  logic               clock = 1'b0;
  logic               rst = 1'b1;
  logic               stall_i = 1'b0;
  logic               redirect_i = 1'b0;
  logic [PC_W-1:0]    redirect_pc_i = '0;
  logic [PC_W-1:0]    imem_addr_o;
  logic [INSTR_W-1:0] imem_rdata_i;
  logic [INSTR_W-1:0] instr_o;
  logic [PC_W-1:0]    npc_o;
  logic               valid_o;
  if_state_e          state_o;
`ifdef IF_HALT_DETECT_EN
  logic               halt_o;
`endif

  always #5 clock = ~clock;

  if_fetch_unit dut (
    .clock         (clock),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .instr_o       (instr_o),
    .npc_o         (npc_o),
    .valid_o       (valid_o),
    .state_o       (state_o)
`ifdef IF_HALT_DETECT_EN
    ,
    .halt_o        (halt_o)
`endif
  );

  // Synchronous instruction memory: data one cycle after the address.
  logic [INSTR_W-1:0] mem [256];
  always @(posedge clock) imem_rdata_i <= mem[imem_addr_o];

  // Scoreboard state
  logic [39:0]        exp_q[$];
  logic [PC_W-1:0]    mdl_pc = '0;
  logic               mdl_halted = 1'b0;
  int                 checks = 0;
  int                 errors = 0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: apply one cycle of inputs and advance the reference stream.
  task automatic drive(input logic s, input logic r, input logic [PC_W-1:0] t);
    stall_i       = s;
    redirect_i    = r;
    redirect_pc_i = t;
    if (!mdl_halted) begin
      if (r) begin
        exp_q.delete();
        mdl_pc = t;
      end else if (!s) begin
        exp_q.push_back({mem[mdl_pc], mdl_pc + 8'd1});
        mdl_pc = mdl_pc + 8'd1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  // Hold reset for two edges with the given stall/redirect levels, check the
  // reset state, then release.
  task automatic do_reset(input logic s, input logic r);
    rst           = 1'b1;
    stall_i       = s;
    redirect_i    = r;
    redirect_pc_i = 8'h77;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    chk("rst_valid", 48'(valid_o), 48'(0));
    chk("rst_instr", 48'(instr_o), 48'(0));
    chk("rst_npc", 48'(npc_o), 48'(0));
    chk("rst_addr", 48'(imem_addr_o), 48'(0));
    chk("rst_state", 48'(state_o), 48'(REFILL));
`ifdef IF_HALT_DETECT_EN
    chk("rst_halt", 48'(halt_o), 48'(0));
`endif
    rst        = 1'b0;
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    exp_q.delete();
    mdl_pc     = '0;
    mdl_halted = 1'b0;
  endtask

  // Run unstalled until the next valid output (bounded) and check it.
  task automatic wait_valid(input string name, input logic [31:0] ei, input logic [7:0] en);
    bit seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (valid_o) seen = 1'b1;
      else drive(1'b0, 1'b0, 8'h00);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: valid_o never rose, expected npc %0h", name, en);
    end else begin
      chk(name, 48'({instr_o, npc_o}), 48'({ei, en}));
    end
  endtask

  // Monitor: stream scoreboard, stall hold, redirect bubble, bubble content.
  logic               prev_rst = 1'b1;
  logic               prev_stall = 1'b0;
  logic               prev_redir = 1'b0;
  logic [40:0]        prev_out = '0;
  logic [39:0]        exp_item;
  always @(negedge clock) begin
    if (!rst) begin
`ifdef IF_HALT_DETECT_EN
      chk("halt_o", 48'(halt_o), 48'(mdl_halted));
`endif
      if (!valid_o) chk("bubble_instr", 48'(instr_o), 48'(0));
      if (!prev_rst && prev_stall && !prev_redir)
        chk("stall_hold", 48'({valid_o, instr_o, npc_o}), 48'(prev_out));
      if (!prev_rst && prev_redir)
        chk("redir_bubble", 48'(valid_o), 48'(0));
      if (valid_o && !stall_i && !redirect_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got instr %0h npc %0h, expected no instruction", instr_o, npc_o);
        end else begin
          exp_item = exp_q.pop_front();
          chk("stream", 48'({instr_o, npc_o}), 48'(exp_item));
`ifdef IF_HALT_DETECT_EN
          if (exp_item[39:8] == HALT_OPCODE) begin
            mdl_halted = 1'b1;
            exp_q.delete();
          end
`endif
        end
      end
    end
    prev_rst   = rst;
    prev_stall = stall_i;
    prev_redir = redirect_i;
    prev_out   = {valid_o, instr_o, npc_o};
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 32'(a * 4);

    // Reset release and first-fetch latency
    do_reset(1'b0, 1'b0);
    chk("lat_c0", 48'(valid_o), 48'(0));
    drive(1'b0, 1'b0, 8'h00);
    chk("lat_c1", 48'(valid_o), 48'(0));
    drive(1'b0, 1'b0, 8'h00);
    chk("first_out", 48'({valid_o, instr_o, npc_o}), 48'({1'b1, 32'h0, 8'h01}));
    for (int k = 2; k <= 5; k++) begin
      drive(1'b0, 1'b0, 8'h00);
      chk("seq_npc", 48'(npc_o), 48'(k));
    end

    // Three-cycle stall while npc 5 is presented
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 8'h00);
      chk("stall_frozen", 48'({valid_o, npc_o}), 48'({1'b1, 8'h05}));
    end
    for (int k = 6; k <= 8; k++) begin
      drive(1'b0, 1'b0, 8'h00);
      chk("post_stall", 48'({valid_o, instr_o, npc_o}), 48'({1'b1, 32'(4 * (k - 1)), 8'(k)}));
    end

    // Redirect to 8'h40
    drive(1'b0, 1'b1, 8'h40);
    chk("redir_40_bubble", 48'(valid_o), 48'(0));
    wait_valid("redir_40", 32'h100, 8'h41);

    // Redirect and stall together
    drive(1'b1, 1'b1, 8'h80);
    chk("redir_stall_bubble", 48'(valid_o), 48'(0));
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    chk("redir_stall_hold", 48'(valid_o), 48'(0));
    wait_valid("redir_stall", 32'h200, 8'h81);

    // Redirect to 8'hFE and wrap
    drive(1'b0, 1'b1, 8'hFE);
    wait_valid("wrap_ff", 32'h3F8, 8'hFF);
    drive(1'b0, 1'b0, 8'h00);
    chk("wrap_00", 48'({instr_o, npc_o}), 48'({32'h3FC, 8'h00}));
    drive(1'b0, 1'b0, 8'h00);
    chk("wrap_01", 48'({instr_o, npc_o}), 48'({32'h0, 8'h01}));

    // Reset in the middle of a stall with the skid entry occupied
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    do_reset(1'b1, 1'b1);
    wait_valid("rst_midstall", 32'h0, 8'h01);
    drive(1'b0, 1'b0, 8'h00);
    chk("rst_midstall_next", 48'(npc_o), 48'(2));

    // Randomized traffic over random memory contents
    for (int a = 0; a < 256; a++) begin
      mem[a] = $urandom();
`ifdef IF_HALT_DETECT_EN
      if (mem[a] == HALT_OPCODE) mem[a] = '0;
`endif
    end
`ifndef IF_HALT_DETECT_EN
    mem[17] = HALT_OPCODE;
`endif
    do_reset(1'b0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 5),
            8'($urandom_range(0, 255)));
    end
    chk("drain", 48'(exp_q.size() <= 2), 48'(1));

`ifdef IF_HALT_DETECT_EN
    // Halt word at address 3
    for (int a = 0; a < 256; a++) mem[a] = 32'(a * 4);
    mem[3] = HALT_OPCODE;
    do_reset(1'b0, 1'b0);
    repeat (10) drive(1'b0, 1'b0, 8'h00);
    chk("halt_set", 48'({halt_o, valid_o}), 48'({1'b1, 1'b0}));
    chk("halt_pc", 48'(imem_addr_o), 48'(5));
    drive(1'b0, 1'b1, 8'h20);
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    chk("halt_after_redir", 48'({halt_o, valid_o}), 48'({1'b1, 1'b0}));
    chk("halt_pc_frozen", 48'(imem_addr_o), 48'(5));
    do_reset(1'b0, 1'b0);
    wait_valid("halt_restart", 32'h0, 8'h01);
`endif

    repeat (2) drive(1'b0, 1'b0, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have port clock, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port stall_i, input, 1 bit: consumer (IF/ID register) cannot accept; hold outputs.
REQ-004 SHALL have port redirect_i, input, 1 bit: branch/jump taken; refetch from redirect_pc_i.
REQ-005 SHALL have port redirect_pc_i, input, 8 bits: target word address.
REQ-006 SHALL have port imem_addr_o, output, 8 bits: instruction memory word address, driven from registered PC.
REQ-007 SHALL have port imem_rdata_i, input, 32 bits: memory data, valid exactly 1 cycle after the address.
REQ-008 SHALL have port instr_o, output, 32 bits: fetched instruction, feeds IF/ID In.
REQ-009 SHALL have port npc_o, output, 8 bits: fetched address + 1 mod 256, feeds IF/ID NPCI.
REQ-010 SHALL have port valid_o, output, 1 bit: instr_o/npc_o hold a real instruction; low means bubble (instr_o = 0).
REQ-011 SHALL, with IF_HALT_DETECT_EN defined, have port halt_o, output, 1 bit: fetch halted.

Function
REQ-012 SHALL keep registered pc_q; imem_addr_o = pc_q; pc_q advances pc_q+1 each cycle not stalled, wrapping 8'hFF -> 8'h00.
REQ-013 SHALL track one in-flight request (inflight_v, inflight_pc) issued in the previous cycle.
REQ-014 SHALL register outputs: when not stalled and inflight_v, next instr_o = imem_rdata_i, npc_o = inflight_pc+1, valid_o = 1.
REQ-015 SHALL yield 2-cycle PC-to-valid_o latency and, unstalled, one valid instruction per cycle.
REQ-016 SHALL, with stall_i high, hold instr_o/npc_o/valid_o and pc_q unchanged and issue no new request.
REQ-017 SHALL, if an in-flight response arrives during a stall, capture it in a 1-entry skid buffer and present it on the first unstalled cycle before any newer data; no instruction lost or duplicated.
REQ-018 SHALL, on redirect_i, set pc_q = redirect_pc_i, drop in-flight and skid contents, and drive valid_o = 0 next cycle.
REQ-019 SHALL give redirect_i priority over stall_i; a redirect during a stall still squashes and loads the new PC.
REQ-020 SHALL use FSM states RUN (normal), HOLD (stall, skid possibly full), REFILL (first cycle after reset or redirect, no data in flight); RUN->HOLD on stall_i, HOLD->RUN on !stall_i, any->REFILL on redirect_i, REFILL->RUN next cycle (or HOLD if stall_i).

Reset
REQ-021 SHALL, while rst is high at a clock edge: pc_q = 0, inflight_v = 0, skid empty, instr_o = 0, npc_o = 0, valid_o = 0, state = REFILL, halt_o = 0.
REQ-022 SHALL let rst override stall_i and redirect_i; reset mid-stall discards the skid entry.
REQ-023 SHALL fetch address 0 in the first cycle after rst deasserts.

Configuration
REQ-024 SHALL, with IF_HALT_DETECT_EN defined, on presenting instr_o == 32'hFFFF_FFFF with valid_o, set halt_o = 1, freeze pc_q, and issue no further valid instructions until rst; a redirect does not clear halt.
REQ-025 SHALL, without IF_HALT_DETECT_EN, omit halt_o and treat 32'hFFFF_FFFF as ordinary data.

Structure
REQ-026 SHALL place PC_W = 8, INSTR_W = 32, HALT_OPCODE, and the FSM state enum in shared package kgp_if_pkg.
REQ-027 SHALL implement the 1-entry skid buffer as sub-module if_skid_buf (data+pc+valid, load/pop/flush).

Verification
REQ-028 SHALL verify reset release with memory returning addr*4: valid_o first high 2 cycles later, instr_o = 0, npc_o = 1, then npc_o 2,3,4 on consecutive cycles.
REQ-029 SHALL verify stall_i high 3 cycles mid-stream at npc_o = 5: outputs frozen; after release npc_o sequence 6,7,8 with no gap or repeat.
REQ-030 SHALL verify redirect_i with redirect_pc_i = 8'h40: one bubble (valid_o = 0), then npc_o = 8'h41 with instr_o = 32'h100.
REQ-031 SHALL verify redirect and stall asserted together: redirect wins; after stall drops, first npc_o = target+1.
REQ-032 SHALL verify redirect to 8'hFE: npc_o = FF, 00, 01 (wrap).
REQ-033 SHALL verify, with IF_HALT_DETECT_EN, memory word 32'hFFFF_FFFF at address 3: halt_o = 1 after it is presented, valid_o stays 0 thereafter, and rst clears halt_o.
